// File: rtl/mdu.sv
// rtl/mdu.sv - iterative 32-bit multiply/divide unit (shift-add multiplier, restoring divider).
// Optional macro MDU_FAST_MUL_EN: multiply ops use a single-cycle array multiplier.
module mdu (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [2:0]  funct3,
    output logic        busy,
    output logic        done,
    output logic [63:0] product,
    output logic [31:0] quotient,
    output logic [31:0] remainder
);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t      state_q;
    logic [5:0]  cnt_q;
    logic [2:0]  op_q;
    logic [31:0] a_q;
    logic [31:0] mag_a_q;
    logic [31:0] mag_b_q;
    logic [63:0] acc_q;
    logic        neg_q;
    logic        neg_rem_q;
    logic        busy_q;
    logic        done_q;
    logic [63:0] product_q;
    logic [31:0] quotient_q;
    logic [31:0] remainder_q;

    logic        a_sgn_in, b_sgn_in, a_neg_in, b_neg_in;
    logic [31:0] mag_a_in, mag_b_in;
    logic [32:0] mul_sum;
    logic        div_ge;
    logic [31:0] div_diff;
    logic [63:0] acc_d;
    logic [63:0] product_d;
    logic [31:0] quotient_d;
    logic [31:0] remainder_d;
    logic        finish_d;

    // Operand signedness: divides use funct3[0]; MUL/MULH signed both, MULHSU signed a only.
    always_comb begin
        a_sgn_in = funct3[2] ? ~funct3[0] : (funct3 != 3'd3);
        b_sgn_in = funct3[2] ? ~funct3[0] : ~funct3[1];
        a_neg_in = a_sgn_in & a[31];
        b_neg_in = b_sgn_in & b[31];
        mag_a_in = a_neg_in ? (~a + 32'd1) : a;
        mag_b_in = b_neg_in ? (~b + 32'd1) : b;
    end

    // acc_q holds {hi, lo}: multiplier in lo for multiply, {remainder, dividend/quotient} for divide.
    always_comb begin
        mul_sum  = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, mag_a_q} : 33'd0);
        div_ge   = acc_q[63:31] >= {1'b0, mag_b_q};
        div_diff = acc_q[62:31] - mag_b_q;
        if (op_q[2]) begin
            acc_d = div_ge ? {div_diff, acc_q[30:0], 1'b1} : {acc_q[62:0], 1'b0};
        end else begin
            acc_d = {mul_sum, acc_q[31:1]};
        end
    end

`ifdef MDU_FAST_MUL_EN
    logic [31:0]        b_q;
    logic signed [65:0] fast_x, fast_y, fast_full;
    always_comb begin
        fast_x    = {{34{(op_q != 3'd3) & a_q[31]}}, a_q};
        fast_y    = {{34{~op_q[1] & b_q[31]}}, b_q};
        fast_full = fast_x * fast_y;
    end
`endif

    always_comb begin
        product_d   = neg_q ? (~acc_q + 64'd1) : acc_q;
        quotient_d  = neg_q ? (~acc_q[31:0] + 32'd1) : acc_q[31:0];
        remainder_d = neg_rem_q ? (~acc_q[63:32] + 32'd1) : acc_q[63:32];
        if (mag_b_q == 32'd0) begin
            quotient_d  = 32'hFFFF_FFFF;
            remainder_d = a_q;
        end
`ifdef MDU_FAST_MUL_EN
        finish_d = (cnt_q == 6'd32) | ~op_q[2];
        if (!op_q[2]) begin
            product_d = fast_full[63:0];
        end
`else
        finish_d = (cnt_q == 6'd32);
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= 6'd0;
            op_q        <= 3'd0;
            a_q         <= 32'd0;
            mag_a_q     <= 32'd0;
            mag_b_q     <= 32'd0;
            acc_q       <= 64'd0;
            neg_q       <= 1'b0;
            neg_rem_q   <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            product_q   <= 64'd0;
            quotient_q  <= 32'd0;
            remainder_q <= 32'd0;
`ifdef MDU_FAST_MUL_EN
            b_q         <= 32'd0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        op_q      <= funct3;
                        a_q       <= a;
                        mag_a_q   <= mag_a_in;
                        mag_b_q   <= mag_b_in;
                        neg_q     <= a_neg_in ^ b_neg_in;
                        neg_rem_q <= a_neg_in;
                        acc_q     <= funct3[2] ? {32'd0, mag_a_in} : {32'd0, mag_b_in};
                        cnt_q     <= 6'd0;
                        busy_q    <= 1'b1;
                        state_q   <= CALC;
`ifdef MDU_FAST_MUL_EN
                        b_q       <= b;
`endif
                    end
                end
                CALC: begin
                    // Extra cycle after the 32nd step applies sign correction and publishes results.
                    if (finish_d) begin
                        if (op_q[2]) begin
                            quotient_q  <= quotient_d;
                            remainder_q <= remainder_d;
                        end else begin
                            product_q   <= product_d;
                        end
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end else begin
                        acc_q <= acc_d;
                        cnt_q <= cnt_q + 6'd1;
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign product   = product_q;
    assign quotient  = quotient_q;
    assign remainder = remainder_q;

endmodule

// File: tb/tb_mdu.sv
// tb/tb_mdu.sv - directed self-checking bench for mdu.
module tb_mdu;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  funct3;
    logic        busy;
    logic        done;
    logic [63:0] product;
    logic [31:0] quotient;
    logic [31:0] remainder;

    int n_vec;
    int n_err;
    int lat;
    bit seen;

`ifdef MDU_FAST_MUL_EN
    localparam int LAT_MUL = 1;
`else
    localparam int LAT_MUL = 33;
`endif
    localparam int LAT_DIV = 33;

    mdu dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .a         (a),
        .b         (b),
        .funct3    (funct3),
        .busy      (busy),
        .done      (done),
        .product   (product),
        .quotient  (quotient),
        .remainder (remainder)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Issue one op, scramble operands and poke start while busy, then check timing of done.
    task automatic do_op(input string tag, input logic [2:0] f, input logic [31:0] x,
                         input logic [31:0] y, input int exp_lat);
        int k;
        @(negedge clk);
        start = 1'b1; funct3 = f; a = x; b = y;
        @(posedge clk);
        #1;
        start = 1'b0; a = $urandom; b = $urandom; funct3 = 3'($urandom_range(0, 7));
        lat = 0;
        for (k = 1; k <= 60; k++) begin
            @(posedge clk);
            #1;
            if (done) begin
                lat = k;
                break;
            end
            if (k == 5) start = 1'b1;
            if (k == 6) start = 1'b0;
        end
        chk({tag, " latency"}, 64'(lat), 64'(exp_lat));
        chk({tag, " busy_at_done"}, 64'(busy), 64'd0);
        @(posedge clk);
        #1;
        chk({tag, " done_single"}, 64'(done), 64'd0);
    endtask

    initial begin
        n_vec = 0; n_err = 0;
        rst_n = 1'b0; start = 1'b0; a = 32'd0; b = 32'd0; funct3 = 3'd0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst busy", 64'(busy), 64'd0);
        chk("rst done", 64'(done), 64'd0);
        chk("rst product", product, 64'd0);
        chk("rst quotient", 64'(quotient), 64'd0);
        chk("rst remainder", 64'(remainder), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        do_op("DIV 20/4", 3'd4, 32'd20, 32'd4, LAT_DIV);
        chk("DIV 20/4 q", 64'(quotient), 64'd5);
        chk("DIV 20/4 r", 64'(remainder), 64'd0);
        do_op("DIV 21/4", 3'd4, 32'd21, 32'd4, LAT_DIV);
        chk("DIV 21/4 q", 64'(quotient), 64'd5);
        chk("DIV 21/4 r", 64'(remainder), 64'd1);
        do_op("DIV -20/4", 3'd4, 32'hFFFF_FFEC, 32'd4, LAT_DIV);
        chk("DIV -20/4 q", 64'(quotient), 64'h0000_0000_FFFF_FFFB);
        chk("DIV -20/4 r", 64'(remainder), 64'd0);
        do_op("REM -21/4", 3'd6, 32'hFFFF_FFEB, 32'd4, LAT_DIV);
        chk("REM -21/4 q", 64'(quotient), 64'h0000_0000_FFFF_FFFB);
        chk("REM -21/4 r", 64'(remainder), 64'h0000_0000_FFFF_FFFF);
        do_op("DIVU 20/4", 3'd5, 32'd20, 32'd4, LAT_DIV);
        chk("DIVU 20/4 q", 64'(quotient), 64'd5);
        chk("DIVU 20/4 r", 64'(remainder), 64'd0);
        do_op("DIVU big/4", 3'd5, 32'hFFFF_FFEC, 32'd4, LAT_DIV);
        chk("DIVU big/4 q", 64'(quotient), 64'h0000_0000_3FFF_FFFB);
        chk("DIVU big/4 r", 64'(remainder), 64'd0);
        do_op("DIV 7/0", 3'd4, 32'd7, 32'd0, LAT_DIV);
        chk("DIV 7/0 q", 64'(quotient), 64'h0000_0000_FFFF_FFFF);
        chk("DIV 7/0 r", 64'(remainder), 64'd7);
        do_op("DIV ovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, LAT_DIV);
        chk("DIV ovf q", 64'(quotient), 64'h0000_0000_8000_0000);
        chk("DIV ovf r", 64'(remainder), 64'd0);
        do_op("REMU 7/0", 3'd7, 32'd7, 32'd0, LAT_DIV);
        chk("REMU 7/0 r", 64'(remainder), 64'd7);
        do_op("REM -7/0", 3'd6, 32'hFFFF_FFF9, 32'd0, LAT_DIV);
        chk("REM -7/0 q", 64'(quotient), 64'h0000_0000_FFFF_FFFF);
        chk("REM -7/0 r", 64'(remainder), 64'h0000_0000_FFFF_FFF9);

        do_op("MULH -1*-1", 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, LAT_MUL);
        chk("MULH -1*-1 p", product, 64'h0000_0000_0000_0001);
        chk("MULH keeps q", 64'(quotient), 64'h0000_0000_FFFF_FFFF);
        chk("MULH keeps r", 64'(remainder), 64'h0000_0000_FFFF_FFF9);
        do_op("MULHU max", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, LAT_MUL);
        chk("MULHU max p", product, 64'hFFFF_FFFE_0000_0001);
        do_op("MULHSU -1*2", 3'd2, 32'hFFFF_FFFF, 32'd2, LAT_MUL);
        chk("MULHSU -1*2 p", product, 64'hFFFF_FFFF_FFFF_FFFE);
        do_op("MUL -3*7", 3'd0, 32'hFFFF_FFFD, 32'd7, LAT_MUL);
        chk("MUL -3*7 p", product, 64'hFFFF_FFFF_FFFF_FFEB);
        do_op("DIVU 100/7", 3'd5, 32'd100, 32'd7, LAT_DIV);
        chk("DIVU 100/7 q", 64'(quotient), 64'd14);
        chk("DIVU 100/7 r", 64'(remainder), 64'd2);
        chk("DIVU keeps p", product, 64'hFFFF_FFFF_FFFF_FFEB);

        // start held high through DONE is re-accepted in the following IDLE cycle
        @(negedge clk);
        start = 1'b1; funct3 = 3'd5; a = 32'd20; b = 32'd4;
        @(posedge clk);
        seen = 1'b0;
        for (int k = 1; k <= 60; k++) begin
            @(posedge clk);
            #1;
            if (done) begin
                lat = k;
                seen = 1'b1;
                break;
            end
        end
        chk("hold first done", 64'(seen), 64'd1);
        chk("hold first q", 64'(quotient), 64'd5);
        funct3 = 3'd4; a = 32'd21; b = 32'd4;
        seen = 1'b0; lat = 0;
        for (int k = 1; k <= 60; k++) begin
            @(posedge clk);
            #1;
            if (done) begin
                lat = k;
                seen = 1'b1;
                break;
            end
        end
        start = 1'b0;
        chk("hold second gap", 64'(lat), 64'd35);
        chk("hold second q", 64'(quotient), 64'd5);
        chk("hold second r", 64'(remainder), 64'd1);
        @(posedge clk);
        @(posedge clk);

        // reset asserted at iteration 10 aborts the op
        @(negedge clk);
        start = 1'b1; funct3 = 3'd4; a = 32'd20; b = 32'd4;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("abort busy", 64'(busy), 64'd0);
        chk("abort done", 64'(done), 64'd0);
        chk("abort product", product, 64'd0);
        chk("abort quotient", 64'(quotient), 64'd0);
        chk("abort remainder", 64'(remainder), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk);
            #1;
            if (done) seen = 1'b1;
        end
        chk("abort no done", 64'(seen), 64'd0);
        do_op("post-rst DIV 20/4", 3'd4, 32'd20, 32'd4, LAT_DIV);
        chk("post-rst q", 64'(quotient), 64'd5);
        chk("post-rst r", 64'(remainder), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
